vga_vbus_ctrl: RTL and testbench

VGA_VBUS_CTRL -- requirements
Module: vga_vbus_ctrl

---
 rtl/vga_vbus_ctrl.sv | 158 +++++++++++++++
 tb/tb_vga_vbus_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_vbus_ctrl.sv
// VGA 640x480 timing generator with a scanout / DMA video-bus arbiter.
// Define VGA_VBUS_FREE_HBLANK_EN to also release the bus during horizontal blanking.
module vga_vbus_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_SHIFT = 2,
  parameter int GUARD     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_hsync_b,
  output logic        o_vsync_b,
  output logic [15:0] o_vram_addr,
  output logic        o_vram_oe_b,
  input  logic [7:0]  i_vram_data,
  output logic [7:0]  o_rgb,
  output logic        o_free_vbus_b,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_END      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_END      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_LO  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_HI  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_LO  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_HI  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_GUARD_LO = 12'(H_TOTAL - GUARD);
`ifdef VGA_VBUS_FREE_HBLANK_EN
  localparam logic [11:0] V_LEAD_LAST = 12'(V_ACTIVE - 1);
`endif

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    GUARD_S = 2'd1,
    SCAN    = 2'd2
  } arb_state_e;

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  arb_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        oe_b_q, oe_b_d;
  logic        hs1_q, hs2_q, vs1_q, vs2_q;
  logic        vis_q;
  logic [7:0]  rgb_q;
  logic        frame_start_q;
  logic        free_q;

  logic        fetch_d, own_d, guard_d, lead_line_d;
  logic        hs_raw_d, vs_raw_d, vis_d, frame_start_d;
  logic [7:0]  h_pix_d, v_pix_d;

  // Every decode below looks at the position the counters move to on this edge,
  // so arbiter state, address and oe line up with h_cnt/v_cnt.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_END) begin
      h_cnt_d = 12'd0;
      if (v_cnt_q == V_END) begin
        v_cnt_d = 12'd0;
      end else begin
        v_cnt_d = v_cnt_q + 12'd1;
      end
    end else begin
      v_cnt_d = v_cnt_q;
    end

    fetch_d       = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hs_raw_d      = !((h_cnt_d >= H_SYNC_LO) && (h_cnt_d < H_SYNC_HI));
    vs_raw_d      = !((v_cnt_d >= V_SYNC_LO) && (v_cnt_d < V_SYNC_HI));
    frame_start_d = (v_cnt_d == V_ACT) && (h_cnt_d == 12'd0);
    h_pix_d       = 8'(h_cnt_d >> PIX_SHIFT);
    v_pix_d       = 8'(v_cnt_d >> PIX_SHIFT);

`ifdef VGA_VBUS_FREE_HBLANK_EN
    // Guard tail of any line whose successor is a visible line.
    lead_line_d = (v_cnt_d == V_END) || (v_cnt_d < V_LEAD_LAST);
    guard_d     = (h_cnt_d >= H_GUARD_LO) && lead_line_d;
    own_d       = fetch_d || guard_d;
`else
    lead_line_d = (v_cnt_d == V_END);
    guard_d     = (h_cnt_d >= H_GUARD_LO) && lead_line_d;
    own_d       = (v_cnt_d < V_ACT) || guard_d;
`endif

    case (state_q)
      FREE:    state_d = own_d ? GUARD_S : FREE;
      GUARD_S: state_d = fetch_d ? SCAN : GUARD_S;
      SCAN:    state_d = own_d ? SCAN : FREE;
      default: state_d = GUARD_S;
    endcase

    vis_d = (state_d == SCAN) && fetch_d;
    if (vis_d) begin
      addr_d = {v_pix_d, h_pix_d};
      oe_b_d = 1'b0;
    end else begin
      addr_d = addr_q;
      oe_b_d = 1'b1;
    end
  end

  // Counters, arbiter FSM and the two-stage video pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      state_q       <= GUARD_S;
      free_q        <= 1'b1;
      addr_q        <= 16'h0000;
      oe_b_q        <= 1'b1;
      hs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      vis_q         <= 1'b0;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      state_q       <= state_d;
      free_q        <= (state_d != FREE);
      addr_q        <= addr_d;
      oe_b_q        <= oe_b_d;
      hs1_q         <= hs_raw_d;
      hs2_q         <= hs1_q;
      vs1_q         <= vs_raw_d;
      vs2_q         <= vs1_q;
      vis_q         <= vis_d;
      // vis_q is the pixel whose data is on i_vram_data now; it becomes the
      // twice-delayed visible flag together with this rgb register.
      rgb_q         <= vis_q ? i_vram_data : 8'h00;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_vram_addr   = (state_q == FREE) ? 16'hzzzz : addr_q;
  assign o_vram_oe_b   = (state_q == FREE) ? 1'bz : oe_b_q;
  assign o_free_vbus_b = free_q;
  assign o_hsync_b     = hs2_q;
  assign o_vsync_b     = vs2_q;
  assign o_rgb         = rgb_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_vbus_ctrl.sv
// Bench for vga_vbus_ctrl on a scaled-down 58x40 raster (40x30 visible) so
// whole frames fit in a short run; literal expectations are for that raster.
module tb_vga_vbus_ctrl;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 30, VF = 3, VS = 2, VB = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int SH = 2;
  localparam int G  = 2;
`ifdef VGA_VBUS_FREE_HBLANK_EN
  localparam logic [15:0] EXP_HBLANK_FREE_B = 16'd0;
`else
  localparam logic [15:0] EXP_HBLANK_FREE_B = 16'd1;
`endif

  logic        clk, rst;
  logic        hsync_b, vsync_b, vram_oe_b, free_b, frame_start;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data, rgb;
  bit          mode_ff;

  int checks = 0;
  int errors = 0;

  int          mh, mv;
  bit          first_q, cur_fetch, prev_hs_b, prev_vs_b;
  logic [7:0]  prev_rgb;
  logic [15:0] last_addr;

  vga_vbus_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_SHIFT(SH), .GUARD(G)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .o_hsync_b(hsync_b), .o_vsync_b(vsync_b),
    .o_vram_addr(vram_addr), .o_vram_oe_b(vram_oe_b),
    .i_vram_data(vram_data), .o_rgb(rgb),
    .o_free_vbus_b(free_b), .o_frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Video RAM: returns the address low byte, or a constant 8'hFF.
  always_comb begin
    vram_data = 8'h00;
    if (mode_ff) vram_data = 8'hFF;
    else         vram_data = vram_addr[7:0];
  end

  function automatic bit fetch_at(int h, int v);
    return (h < HA) && (v < VA);
  endfunction

  // Owned if fetching now or if a fetch position lies within the next G clocks.
  function automatic bit owned_at(int h, int v);
    int hh = h;
    int vv = v;
    bit own = fetch_at(h, v);
`ifndef VGA_VBUS_FREE_HBLANK_EN
    if (v < VA) own = 1'b1;
`endif
    for (int k = 0; k < G; k++) begin
      hh++;
      if (hh == HT) begin
        hh = 0;
        vv = (vv + 1) % VT;
      end
      if (fetch_at(hh, vv)) own = 1'b1;
    end
    return own;
  endfunction

  function automatic bit sync_low(int c, int act, int fp, int sw);
    return (c >= act + fp) && (c < act + fp + sw);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at v=%0d h=%0d: got %h expected %h", name, mv, mh, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      mh = 0; mv = 0; first_q = 1'b1;
      prev_hs_b = 1'b1; prev_vs_b = 1'b1;
      prev_rgb = 8'h00; last_addr = 16'h0000;
    end else begin
      prev_rgb  = cur_fetch ? (mode_ff ? 8'hFF : last_addr[7:0]) : 8'h00;
      prev_hs_b = !sync_low(mh, HA, HF, HS);
      prev_vs_b = !sync_low(mv, VA, VF, VS);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
      first_q = 1'b0;
    end
  endtask

  task automatic compare();
    bit own;
    cur_fetch = fetch_at(mh, mv) && !first_q;
    if (cur_fetch) last_addr = {8'(mv >> SH), 8'(mh >> SH)};
    own = owned_at(mh, mv);
    chk("free_vbus_b", 16'(free_b), 16'(own));
    if (own) begin
      chk("vram_oe_b", 16'(vram_oe_b), 16'(!cur_fetch));
      chk("vram_addr", vram_addr, last_addr);
    end
    chk("hsync_b", 16'(hsync_b), 16'(prev_hs_b));
    chk("vsync_b", 16'(vsync_b), 16'(prev_vs_b));
    chk("rgb", 16'(rgb), 16'(prev_rgb));
    chk("frame_start", 16'(frame_start), 16'((mv == VA) && (mh == 0)));
  endtask

  task automatic literals();
    if (mv == 5 && mh == 13) chk("addr_5_13", vram_addr, 16'h0103);
    if (mv == 5 && mh == 15 && !mode_ff) chk("rgb_5_15", 16'(rgb), 16'h0003);
    if (mv == 30 && mh == 0) chk("fs_30_0", 16'(frame_start), 16'd1);
    if (mv == 39 && mh == 55) chk("free_39_55", 16'(free_b), 16'd0);
    if (mv == 39 && mh == 56) begin
      chk("free_39_56", 16'(free_b), 16'd1);
      chk("addr_39_56", vram_addr, 16'h0709);
    end
    if (mv == 0 && mh == 0 && !first_q) chk("oe_0_0", 16'(vram_oe_b), 16'd0);
    if (mv == 10 && mh == 40) chk("free_10_40", 16'(free_b), EXP_HBLANK_FREE_B);
    if (mv == 10 && mh == 56) chk("free_10_56", 16'(free_b), 16'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    literals();
  endtask

  initial begin
    int vs_low;
    int fs_cnt;
    rst = 1'b1; mode_ff = 1'b0;
    mh = 0; mv = 0; first_q = 1'b1; cur_fetch = 1'b0;
    prev_hs_b = 1'b1; prev_vs_b = 1'b1; prev_rgb = 8'h00; last_addr = 16'h0000;

    repeat (3) step();
    chk("rst_free", 16'(free_b), 16'd1);
    chk("rst_hsync", 16'(hsync_b), 16'd1);
    chk("rst_vsync", 16'(vsync_b), 16'd1);
    chk("rst_rgb", 16'(rgb), 16'h0000);
    chk("rst_fs", 16'(frame_start), 16'd0);

    rst = 1'b0;
    vs_low = 0;
    fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      if (!vsync_b) vs_low++;
      if (frame_start) fs_cnt++;
    end
    chk("vsync_low_clocks", 16'(vs_low), 16'd116);
    chk("frame_start_count", 16'(fs_cnt), 16'd1);

    for (int i = 0; i < HT * VT; i++) step();

    mode_ff = 1'b1;
    for (int i = 0; i < HT * VT; i++) step();

    for (int i = 0; i < HT * VT && !(mv == 35 && mh == 20); i++) step();
    chk("reach_v35", 16'(mv), 16'd35);
    rst = 1'b1;
    step();
    chk("midrst_free", 16'(free_b), 16'd1);
    chk("midrst_addr", vram_addr, 16'h0000);
    chk("midrst_oe", 16'(vram_oe_b), 16'd1);
    rst = 1'b0;
    mode_ff = 1'b0;
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
